// File: rtl/vid_pixel_fifo.sv
// vid_pixel_fifo
//   Pixel FIFO between a bursting bus read master and the video output stage.
//   Stores 24-bit RGB words and requests refills of BURST words whenever enough
//   space is free. Read-return words that were requested before a flush are
//   discarded when they arrive.
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   wr_valid   read-return word present; wr_data = {8'h00, R, G, B}, [31:24] ignored
//   pix_rd     video stage pops one pixel (R/G/B update one cycle later)
//   flush      frame-start flush of all stored pixels
//   clr_err    clears the sticky underflow/overflow flags
//   fill_req   one-cycle pulse requesting a BURST-word read
//   R, G, B    registered pixel colour
//   level      stored entry count, 0..DEPTH
//   underflow  sticky: pop while empty
//   overflow   sticky: write while full without a pop
module vid_pixel_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_data,
  input  logic                     pix_rd,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic                     fill_req,
  output logic [7:0]               R,
  output logic [7:0]               G,
  output logic [7:0]               B,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(BURST) + 1;
  localparam logic [AW:0] FULL   = (AW + 1)'(DEPTH);
  localparam logic [AW:0] THRESH = (AW + 1)'(DEPTH - BURST);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] beat_rem;
  logic [CW-1:0] drop_rem;
  logic          dropping;
  logic          do_pop;
  logic          do_wr;
  logic          beat_take;
  logic          unused_hi;

  assign unused_hi = ^wr_data[31:24];

  always_comb begin
    dropping  = (drop_cnt != '0);
    do_pop    = pix_rd && (level != '0);
    do_wr     = wr_valid && !dropping && ((level != FULL) || do_pop);
    beat_take = wr_valid && !dropping && (state == WAIT);
    // Requests wait until stale post-flush words have drained, so at most one
    // burst is ever outstanding and the counters stay BURST-sized.
    fill_req  = !reset && !flush && (state == IDLE) && !dropping && (level <= THRESH);
    drop_rem  = (dropping && wr_valid) ? drop_cnt - 1'b1 : drop_cnt;
    beat_rem  = beat_take ? beat_cnt - 1'b1 : beat_cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_wr) begin
      mem[wr_ptr] <= wr_data[23:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      R        <= '0;
      G        <= '0;
      B        <= '0;
      state    <= IDLE;
      beat_cnt <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      R        <= '0;
      G        <= '0;
      B        <= '0;
      state    <= IDLE;
      beat_cnt <= '0;
      // Words still owed by the bus (including this cycle's beat) get discarded.
      drop_cnt <= drop_rem + beat_rem;
    end else begin
      drop_cnt <= drop_rem;
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pix_rd) begin
        if (do_pop) begin
          {R, G, B} <= mem[rd_ptr];
          rd_ptr    <= rd_ptr + 1'b1;
        end else begin
          {R, G, B} <= '0;
        end
      end
      if (do_wr && !do_pop) begin
        level <= level + 1'b1;
      end else if (!do_wr && do_pop) begin
        level <= level - 1'b1;
      end
      case (state)
        IDLE: begin
          if (fill_req) begin
            state    <= WAIT;
            beat_cnt <= CW'(BURST);
          end
        end
        default: begin
          if (beat_take) begin
            if (beat_cnt == CW'(1)) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_rem;
            end
          end
        end
      endcase
    end
  end

  // A new error in the same cycle wins over clr_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (!flush && wr_valid && !dropping && !do_wr) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (!flush && pix_rd && !do_pop) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vid_pixel_fifo.sv
module tb_vid_pixel_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        pix_rd;
  logic        flush;
  logic        clr_err;
  logic        fill_req;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;
  logic [4:0]  level;
  logic        underflow;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  vid_pixel_fifo #(.DEPTH(16), .BURST(4)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .pix_rd(pix_rd), .flush(flush), .clr_err(clr_err), .fill_req(fill_req),
    .R(R), .G(G), .B(B), .level(level), .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hFF000000 | ((i * 32'h00030507 + 32'h00102030) & 32'h00FFFFFF);
  endfunction

  function automatic logic [31:0] rgb24(input logic [31:0] w);
    return w & 32'h00FFFFFF;
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  logic [31:0] rgb;
  logic [31:0] words4 [4];

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; pix_rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
    words4[0] = 32'h00112233; words4[1] = 32'h00223344;
    words4[2] = 32'h00334455; words4[3] = 32'h00445566;

    // Reset state
    tick();
    tick();
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_rgb", {8'h00, R, G, B}, 32'd0);
    check_eq("rst_flags", {30'd0, underflow, overflow}, 32'd0);
    check_eq("rst_fill_req", 32'(fill_req), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_fill_req", 32'(fill_req), 32'd1);
    tick();
    check_eq("wait_fill_req", 32'(fill_req), 32'd0);
    for (int i = 0; i < 4; i++) push(words4[i]);
    check_eq("burst_level", 32'(level), 32'd4);
    check_eq("second_fill_req", 32'(fill_req), 32'd1);
    tick();
    check_eq("second_fill_ends", 32'(fill_req), 32'd0);
    pix_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("burst_rgb", {8'h00, R, G, B}, words4[i]);
    end
    pix_rd = 1'b0;

    // 16-deep fill and drain
    do_reset();
    for (int i = 0; i < 16; i++) push(pat(i));
    check_eq("full_level", 32'(level), 32'd16);
    pix_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq("drain_rgb", {8'h00, R, G, B}, rgb24(pat(i)));
    end
    pix_rd = 1'b0;
    check_eq("drain_level", 32'(level), 32'd0);
    check_eq("drain_flags", {30'd0, underflow, overflow}, 32'd0);
    tick();
    check_eq("hold_rgb", {8'h00, R, G, B}, rgb24(pat(15)));

    // Underflow and sticky-flag clearing
    pix_rd = 1'b1;
    tick();
    check_eq("uf_rgb", {8'h00, R, G, B}, 32'd0);
    check_eq("uf_flag", 32'(underflow), 32'd1);
    clr_err = 1'b1;
    tick();
    check_eq("uf_clr_vs_new", 32'(underflow), 32'd1);
    pix_rd = 1'b0;
    tick();
    clr_err = 1'b0;
    check_eq("uf_cleared", 32'(underflow), 32'd0);

    // Full: write+pop accepted, write alone dropped
    for (int i = 0; i < 16; i++) push(pat(100 + i));
    check_eq("ov_full_level", 32'(level), 32'd16);
    wr_valid = 1'b1; wr_data = pat(200); pix_rd = 1'b1;
    tick();
    check_eq("ov_simul_level", 32'(level), 32'd16);
    check_eq("ov_simul_flag", 32'(overflow), 32'd0);
    check_eq("ov_simul_rgb", {8'h00, R, G, B}, rgb24(pat(100)));
    pix_rd = 1'b0; wr_data = pat(201);
    tick();
    wr_valid = 1'b0;
    check_eq("ov_flag", 32'(overflow), 32'd1);
    check_eq("ov_level", 32'(level), 32'd16);
    pix_rd = 1'b1;
    for (int i = 1; i < 17; i++) begin
      tick();
      rgb = (i < 16) ? rgb24(pat(100 + i)) : rgb24(pat(200));
      check_eq("ov_drain_rgb", {8'h00, R, G, B}, rgb);
    end
    pix_rd = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_eq("ov_cleared", 32'(overflow), 32'd0);

    // Interleaved writes and pops across pointer wrap
    push(pat(300));
    for (int i = 1; i < 20; i++) begin
      wr_valid = 1'b1; wr_data = pat(300 + i); pix_rd = 1'b1;
      tick();
      check_eq("wrap_rgb", {8'h00, R, G, B}, rgb24(pat(300 + i - 1)));
      check_eq("wrap_level", 32'(level), 32'd1);
    end
    wr_valid = 1'b0;
    tick();
    pix_rd = 1'b0;
    check_eq("wrap_last_rgb", {8'h00, R, G, B}, rgb24(pat(319)));
    check_eq("wrap_flags", {30'd0, underflow, overflow}, 32'd0);

    // Flush mid-burst, stale beats dropped
    do_reset();
    tick();
    push(pat(400));
    push(pat(401));
    check_eq("fl_pre_level", 32'(level), 32'd2);
    flush = 1'b1; pix_rd = 1'b1;
    tick();
    flush = 1'b0; pix_rd = 1'b0;
    check_eq("fl_level", 32'(level), 32'd0);
    check_eq("fl_rgb", {8'h00, R, G, B}, 32'd0);
    check_eq("fl_no_uf", 32'(underflow), 32'd0);
    check_eq("fl_fill_held", 32'(fill_req), 32'd0);
    push(pat(402));
    check_eq("fl_drop1_level", 32'(level), 32'd0);
    push(pat(403));
    check_eq("fl_drop2_level", 32'(level), 32'd0);
    check_eq("fl_refill_req", 32'(fill_req), 32'd1);
    push(pat(404));
    check_eq("fl_resume_level", 32'(level), 32'd1);
    check_eq("fl_flags", {30'd0, underflow, overflow}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
